// File: rtl/mem_arbiter.sv
// Two-to-one round-robin arbiter between I-cache, D-cache and one memory port.
// Keeps a write-back and the refill read that follows it together on the port.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    // I-cache side
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    // D-cache side
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_owner
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_sticky;

    logic              w_mem_read_nxt;
    logic              w_mem_write_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_owner_nxt;
    logic              w_last_owner_nxt;
    logic              w_sticky_nxt;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_d;
    logic              w_busy_done;

    assign w_i_req     = i_mem_read | i_mem_write;
    assign w_d_req     = d_mem_read | d_mem_write;
    assign w_busy_done = (r_state == S_BUSY) && mem_ready;

    // Tie-break: sticky re-grants the last owner so its refill follows its write-back.
    always_comb begin
        w_grant_d = w_d_req;
        if (w_i_req && w_d_req) begin
            w_grant_d = r_sticky ? r_last_owner : ~r_last_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_state      <= S_IDLE;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
            r_sticky     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_read   <= w_mem_read_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_sticky     <= w_sticky_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_mem_read_nxt   = r_mem_read;
        w_mem_write_nxt  = r_mem_write;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_sticky_nxt     = r_sticky;

        case (r_state)
            S_IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_state_nxt  = S_BUSY;
                    w_owner_nxt  = w_grant_d;
                    w_sticky_nxt = 1'b0;
                    // A simultaneous read and write on one port issues only the write.
                    if (w_grant_d) begin
                        w_mem_write_nxt = d_mem_write;
                        w_mem_read_nxt  = d_mem_read & ~d_mem_write;
                        w_mem_addr_nxt  = d_mem_addr;
                        w_mem_wdata_nxt = d_mem_wdata;
                    end else begin
                        w_mem_write_nxt = i_mem_write;
                        w_mem_read_nxt  = i_mem_read & ~i_mem_write;
                        w_mem_addr_nxt  = i_mem_addr;
                        w_mem_wdata_nxt = i_mem_wdata;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    w_state_nxt      = S_IDLE;
                    w_mem_read_nxt   = 1'b0;
                    w_mem_write_nxt  = 1'b0;
                    w_last_owner_nxt = r_owner;
                    w_sticky_nxt     = r_mem_write;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Completion goes straight back to the owner; suppressed while reset is asserted.
    assign i_mem_ready = proc_reset_n & w_busy_done & ~r_owner;
    assign d_mem_ready = proc_reset_n & w_busy_done & r_owner;

    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_owner = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: one table row per clock cycle,
// plus a hand-written sequence for reset during an outstanding request.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned NVEC   = 33;

    localparam logic [DATA_W-1:0] I_WD = {4{32'h1111_AAAA}};
    localparam logic [DATA_W-1:0] D_WD = {4{32'h2222_BBBB}};

    logic              clk;
    logic              proc_reset_n;
    logic              i_mem_read, i_mem_write;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_wdata, i_mem_rdata;
    logic              i_mem_ready;
    logic              d_mem_read, d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata, d_mem_rdata;
    logic              d_mem_ready;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_ready;
    logic              mem_owner;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_mem_addr   (i_mem_addr),
        .i_mem_wdata  (i_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_ready  (i_mem_ready),
        .d_mem_read   (d_mem_read),
        .d_mem_write  (d_mem_write),
        .d_mem_addr   (d_mem_addr),
        .d_mem_wdata  (d_mem_wdata),
        .d_mem_rdata  (d_mem_rdata),
        .d_mem_ready  (d_mem_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_owner    (mem_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected during that cycle.
    // ws selects expected mem_wdata: 0 = reset zero, 1 = I data, 2 = D data.
    typedef struct {
        logic              ir, iw;
        logic [ADDR_W-1:0] ia;
        logic              dr, dw;
        logic [ADDR_W-1:0] da;
        logic              rdy;
        logic              er, ew;
        logic [ADDR_W-1:0] ea;
        logic [1:0]        ws;
        logic              eo, eir, edr;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(input int ir, input int iw, input int ia,
                                input int dr, input int dw, input int da,
                                input int rdy,
                                input int er, input int ew, input int ea,
                                input int ws, input int eo, input int eir,
                                input int edr);
        vec_t v;
        v.ir  = 1'(ir);  v.iw = 1'(iw);  v.ia = 28'(ia);
        v.dr  = 1'(dr);  v.dw = 1'(dw);  v.da = 28'(da);
        v.rdy = 1'(rdy);
        v.er  = 1'(er);  v.ew = 1'(ew);  v.ea = 28'(ea);
        v.ws  = 2'(ws);  v.eo = 1'(eo);
        v.eir = 1'(eir); v.edr = 1'(edr);
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] wd_of(input logic [1:0] ws);
        case (ws)
            2'd1:    return I_WD;
            2'd2:    return D_WD;
            default: return '0;
        endcase
    endfunction

    initial begin
        proc_reset_n = 1'b0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_addr = '0; i_mem_wdata = I_WD;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = D_WD;
        mem_rdata = '0; mem_ready = 1'b0;

        //           ir iw ia     dr dw da     rdy er ew ea    ws eo eir edr
        tbl[0]  = mk(1, 0, 'h10,  0, 0, 'h00,  0,  0, 0, 'h00, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 'h10,  0, 0, 'h00,  0,  1, 0, 'h10, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 'h10,  0, 0, 'h00,  1,  1, 0, 'h10, 1, 0, 1, 0);
        tbl[3]  = mk(0, 0, 'h00,  0, 0, 'h00,  0,  0, 0, 'h10, 1, 0, 0, 0);
        tbl[4]  = mk(1, 0, 'h10,  1, 0, 'h20,  0,  0, 0, 'h10, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 'h10,  1, 0, 'h20,  0,  1, 0, 'h20, 2, 1, 0, 0);
        tbl[6]  = mk(1, 0, 'h10,  1, 0, 'h20,  1,  1, 0, 'h20, 2, 1, 0, 1);
        tbl[7]  = mk(1, 0, 'h10,  0, 0, 'h00,  0,  0, 0, 'h20, 2, 1, 0, 0);
        tbl[8]  = mk(1, 0, 'h10,  0, 0, 'h00,  1,  1, 0, 'h10, 1, 0, 1, 0);
        tbl[9]  = mk(1, 0, 'h10,  1, 0, 'h20,  0,  0, 0, 'h10, 1, 0, 0, 0);
        tbl[10] = mk(1, 0, 'h10,  1, 0, 'h20,  1,  1, 0, 'h20, 2, 1, 0, 1);
        tbl[11] = mk(1, 0, 'h10,  1, 0, 'h20,  0,  0, 0, 'h20, 2, 1, 0, 0);
        tbl[12] = mk(1, 0, 'h10,  1, 0, 'h20,  1,  1, 0, 'h10, 1, 0, 1, 0);
        tbl[13] = mk(0, 0, 'h00,  0, 0, 'h00,  0,  0, 0, 'h10, 1, 0, 0, 0);
        // write-back then refill from D while I waits
        tbl[14] = mk(1, 0, 'h40,  0, 1, 'h30,  0,  0, 0, 'h10, 1, 0, 0, 0);
        tbl[15] = mk(1, 0, 'h40,  0, 1, 'h30,  0,  0, 1, 'h30, 2, 1, 0, 0);
        tbl[16] = mk(1, 0, 'h40,  0, 1, 'h30,  1,  0, 1, 'h30, 2, 1, 0, 1);
        tbl[17] = mk(1, 0, 'h40,  1, 0, 'h31,  0,  0, 0, 'h30, 2, 1, 0, 0);
        tbl[18] = mk(1, 0, 'h40,  1, 0, 'h31,  1,  1, 0, 'h31, 2, 1, 0, 1);
        tbl[19] = mk(1, 0, 'h40,  1, 0, 'h32,  0,  0, 0, 'h31, 2, 1, 0, 0);
        tbl[20] = mk(1, 0, 'h40,  1, 0, 'h32,  1,  1, 0, 'h40, 1, 0, 1, 0);
        tbl[21] = mk(0, 0, 'h00,  0, 0, 'h00,  0,  0, 0, 'h40, 1, 0, 0, 0);
        // hold while busy; I request dropped before grant; spurious ready
        tbl[22] = mk(0, 0, 'h00,  1, 0, 'h50,  0,  0, 0, 'h40, 1, 0, 0, 0);
        tbl[23] = mk(0, 0, 'h00,  1, 0, 'h60,  0,  1, 0, 'h50, 2, 1, 0, 0);
        tbl[24] = mk(1, 0, 'h70,  1, 0, 'h60,  0,  1, 0, 'h50, 2, 1, 0, 0);
        tbl[25] = mk(1, 0, 'h70,  1, 0, 'h60,  1,  1, 0, 'h50, 2, 1, 0, 1);
        tbl[26] = mk(0, 0, 'h00,  0, 0, 'h00,  0,  0, 0, 'h50, 2, 1, 0, 0);
        tbl[27] = mk(0, 0, 'h00,  0, 0, 'h00,  1,  0, 0, 'h50, 2, 1, 0, 0);
        tbl[28] = mk(0, 0, 'h00,  0, 0, 'h00,  0,  0, 0, 'h50, 2, 1, 0, 0);
        // illegal read+write from I issues a write
        tbl[29] = mk(1, 1, 'h80,  0, 0, 'h00,  0,  0, 0, 'h50, 2, 1, 0, 0);
        tbl[30] = mk(1, 1, 'h80,  0, 0, 'h00,  0,  0, 1, 'h80, 1, 0, 0, 0);
        tbl[31] = mk(1, 1, 'h80,  0, 0, 'h00,  1,  0, 1, 'h80, 1, 0, 1, 0);
        tbl[32] = mk(0, 0, 'h00,  0, 0, 'h00,  0,  0, 0, 'h80, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        chk("reset mem_read",  128'(mem_read),    128'(0));
        chk("reset mem_write", 128'(mem_write),   128'(0));
        chk("reset mem_addr",  128'(mem_addr),    128'(0));
        chk("reset mem_wdata", 128'(mem_wdata),   128'(0));
        chk("reset owner",     128'(mem_owner),   128'(0));
        chk("reset i_ready",   128'(i_mem_ready), 128'(0));
        chk("reset d_ready",   128'(d_mem_ready), 128'(0));
        proc_reset_n = 1'b1;

        for (int k = 0; k < int'(NVEC); k++) begin
            logic [DATA_W-1:0] rd;
            @(negedge clk);
            rd          = {4{32'hA5A5_0000 | 32'(k)}};
            i_mem_read  = tbl[k].ir;  i_mem_write = tbl[k].iw;  i_mem_addr = tbl[k].ia;
            d_mem_read  = tbl[k].dr;  d_mem_write = tbl[k].dw;  d_mem_addr = tbl[k].da;
            mem_ready   = tbl[k].rdy; mem_rdata   = rd;
            #1;
            chk($sformatf("v%0d mem_read", k),  128'(mem_read),    128'(tbl[k].er));
            chk($sformatf("v%0d mem_write", k), 128'(mem_write),   128'(tbl[k].ew));
            chk($sformatf("v%0d mem_addr", k),  128'(mem_addr),    128'(tbl[k].ea));
            chk($sformatf("v%0d mem_wdata", k), 128'(mem_wdata),   128'(wd_of(tbl[k].ws)));
            chk($sformatf("v%0d owner", k),     128'(mem_owner),   128'(tbl[k].eo));
            chk($sformatf("v%0d i_ready", k),   128'(i_mem_ready), 128'(tbl[k].eir));
            chk($sformatf("v%0d d_ready", k),   128'(d_mem_ready), 128'(tbl[k].edr));
            chk($sformatf("v%0d i_rdata", k),   128'(i_mem_rdata), 128'(rd));
            chk($sformatf("v%0d d_rdata", k),   128'(d_mem_rdata), 128'(rd));
        end

        // Reset while a D read is outstanding; the sticky flag is set from the I write above.
        @(negedge clk);
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_addr = '0;
        d_mem_read = 1'b1; d_mem_write = 1'b0; d_mem_addr = 28'h90;
        mem_ready  = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid granted read", 128'(mem_read), 128'(1));
        chk("rst_mid granted addr", 128'(mem_addr), 128'(28'h90));
        proc_reset_n = 1'b0;
        mem_ready    = 1'b1;
        #1;
        chk("rst_mid d_ready gated", 128'(d_mem_ready), 128'(0));
        chk("rst_mid i_ready gated", 128'(i_mem_ready), 128'(0));
        @(negedge clk);
        proc_reset_n = 1'b1;
        mem_ready    = 1'b0;
        i_mem_read = 1'b1; i_mem_addr = 28'h10;
        d_mem_read = 1'b1; d_mem_addr = 28'h20;
        #1;
        chk("rst_mid dropped read", 128'(mem_read),  128'(0));
        chk("rst_mid owner",        128'(mem_owner), 128'(0));
        chk("rst_mid addr",         128'(mem_addr),  128'(0));
        chk("rst_mid wdata",        128'(mem_wdata), 128'(0));
        @(negedge clk);
        #1;
        chk("post_rst tie read",  128'(mem_read),  128'(1));
        chk("post_rst tie owner", 128'(mem_owner), 128'(1));
        chk("post_rst tie addr",  128'(mem_addr),  128'(28'h20));
        mem_ready = 1'b1;
        #1;
        chk("post_rst d_ready", 128'(d_mem_ready), 128'(1));
        chk("post_rst i_ready", 128'(i_mem_ready), 128'(0));
        @(negedge clk);
        mem_ready = 1'b0;
        i_mem_read = 1'b0; d_mem_read = 1'b0;
        #1;
        chk("post_rst done read", 128'(mem_read), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
